// File: rtl/alu_ctrl_if.sv
// Handshake bundle between decode, the ALU control stage and execute.
// The slave view belongs to alu_ctrl, the master view to its surroundings.
interface alu_ctrl_if #(
    parameter int IW  = 32,
    parameter int OPW = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [IW-1:0]  instr;
    logic           out_valid;
    logic           out_ready;
    logic [OPW-1:0] aluop;
    logic           use_imm;
    logic           is_branch;
    logic           illegal;

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, aluop, use_imm, is_branch, illegal
    );

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, aluop, use_imm, is_branch, illegal
    );
endinterface

// File: rtl/alu_ctrl.sv
// RV64I ALU control: decodes an instruction word into ALU op and operand
// flags behind a registered output with a one-entry skid buffer.
module alu_ctrl #(
    parameter int IW  = 32,
    parameter int OPW = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_ctrl_if.slave  bus
);
    typedef struct packed {
        logic [OPW-1:0] aluop;
        logic           use_imm;
        logic           is_branch;
        logic           illegal;
    } dec_t;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] FULL  = 2'b11;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [OPW-1:0] ALU_AND  = 4'b0000;
    localparam logic [OPW-1:0] ALU_OR   = 4'b0001;
    localparam logic [OPW-1:0] ALU_ADD  = 4'b0010;
    localparam logic [OPW-1:0] ALU_SUB  = 4'b0110;
    localparam logic [OPW-1:0] ALU_NONE = 4'b1111;

    localparam dec_t DEC_ILL = '{ALU_NONE, 1'b0, 1'b0, 1'b1};
    localparam dec_t DEC_RST = '{ALU_NONE, 1'b0, 1'b0, 1'b0};

    logic [1:0] state_q, state_d;
    dec_t       m_q, m_d;
    dec_t       s_q, s_d;
    dec_t       dec;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       accept;
    logic       consume;
    logic       unused_instr;

    assign opcode = bus.instr[6:0];
    assign f3     = bus.instr[14:12];
    assign f7     = bus.instr[31:25];

    // Register numbers and immediates never influence the ALU control word.
    assign unused_instr = ^{bus.instr[24:15], bus.instr[11:7]};

    function automatic dec_t legal(logic [OPW-1:0] op, logic imm, logic br);
        return '{op, imm, br, 1'b0};
    endfunction

    // Combinational decode of the incoming word; unknown encodings fall to ILL.
    always_comb begin
        dec = DEC_ILL;
        unique case (opcode)
            OP_R: begin
                if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
                    unique case (f3)
                        3'b000:  dec = legal(f7[5] ? ALU_SUB : ALU_ADD, 1'b0, 1'b0);
                        3'b111:  dec = legal(ALU_AND, 1'b0, 1'b0);
                        3'b110:  dec = legal(ALU_OR, 1'b0, 1'b0);
                        default: dec = DEC_ILL;
                    endcase
                end
            end
            OP_I: begin
                unique case (f3)
                    3'b000:  dec = legal(ALU_ADD, 1'b1, 1'b0);
                    3'b111:  dec = legal(ALU_AND, 1'b1, 1'b0);
                    3'b110:  dec = legal(ALU_OR, 1'b1, 1'b0);
                    default: dec = DEC_ILL;
                endcase
            end
            OP_LD, OP_ST: dec = legal(ALU_ADD, 1'b1, 1'b0);
            OP_BR: begin
                if (f3 == 3'b000 || f3 == 3'b001) begin
                    dec = legal(ALU_SUB, 1'b0, 1'b1);
                end
            end
            default: dec = DEC_ILL;
        endcase
    end

    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.aluop     = m_q.aluop;
    assign bus.use_imm   = m_q.use_imm;
    assign bus.is_branch = m_q.is_branch;
    assign bus.illegal   = m_q.illegal;

    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = bus.out_valid && bus.out_ready;

    // Main/skid occupancy: new words land in M unless M is stalled, then in S.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    m_d     = dec;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (consume && accept) begin
                    m_d = dec;
                end else if (consume) begin
                    state_d = EMPTY;
                end else if (accept) begin
                    s_d     = dec;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (consume) begin
                    m_d     = s_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State and payload registers; reset discards both entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            m_q     <= DEC_RST;
            s_q     <= DEC_RST;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// Testbench for alu_ctrl: directed decode vectors, back-pressure,
// random handshake traffic against a scoreboard, and reset while full.
module tb_alu_ctrl;
    typedef logic [6:0] exp_t;

    localparam int NV = 17;
    localparam int NR = 10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    logic [31:0] v_ins[NV];
    exp_t        v_exp[NV];

    always #5 clk = ~clk;

    alu_ctrl_if bus ();

    alu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic exp_t obs();
        return {bus.aluop, bus.use_imm, bus.is_branch, bus.illegal};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected word: {aluop, use_imm, is_branch, illegal}
    task automatic load_vectors();
        v_ins[0]  = 32'h00B50533; v_exp[0]  = 7'b0010_000;
        v_ins[1]  = 32'h40B50533; v_exp[1]  = 7'b0110_000;
        v_ins[2]  = 32'h00B57533; v_exp[2]  = 7'b0000_000;
        v_ins[3]  = 32'h00B56533; v_exp[3]  = 7'b0001_000;
        v_ins[4]  = 32'h00A50513; v_exp[4]  = 7'b0010_100;
        v_ins[5]  = 32'h0FF57513; v_exp[5]  = 7'b0000_100;
        v_ins[6]  = 32'h0FF56513; v_exp[6]  = 7'b0001_100;
        v_ins[7]  = 32'h00B50463; v_exp[7]  = 7'b0110_010;
        v_ins[8]  = 32'h00B51463; v_exp[8]  = 7'b0110_010;
        v_ins[9]  = 32'h00853503; v_exp[9]  = 7'b0010_100;
        v_ins[10] = 32'h00A53423; v_exp[10] = 7'b0010_100;
        v_ins[11] = 32'h0000006F; v_exp[11] = 7'b1111_001;
        v_ins[12] = 32'h00B54533; v_exp[12] = 7'b1111_001;
        v_ins[13] = 32'h02B50533; v_exp[13] = 7'b1111_001;
        v_ins[14] = 32'h00B54463; v_exp[14] = 7'b1111_001;
        v_ins[15] = 32'h00151513; v_exp[15] = 7'b1111_001;
        v_ins[16] = 32'h123452B7; v_exp[16] = 7'b1111_001;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr     = 32'h00B50533;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
        checks++;
        if (obs() !== 7'b1111_000) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=1111000", obs());
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got=%b want=0", bus.out_valid);
        end
    endtask

    task automatic test_decode();
        logic pend;
        exp_t e;
        pend = 1'b0;
        sb.delete();
        for (int i = 0; i < NV + 2; i++) begin
            bus.out_ready = 1'b1;
            bus.in_valid  = (i < NV);
            bus.instr     = 32'h0;
            if (i < NV) bus.instr = v_ins[i];
            if (pend) begin
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL decode_latency idx=%0d got=%b want=1", i - 1, bus.out_valid);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL decode_spurious got=%b want=none", obs());
                end else begin
                    e = sb.pop_front();
                    if (obs() !== e) begin
                        errors++;
                        $display("FAIL decode idx=%0d got=%b want=%b", i - 1, obs(), e);
                    end
                end
            end
            pend = bus.in_valid && bus.in_ready;
            if (pend) sb.push_back(v_exp[i]);
            step();
        end
        checks++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL decode_drain got=%0d/%b want=0/0", sb.size(), bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] abc[3];
        exp_t        abc_e[3];
        int          k;
        int          popped;
        exp_t        e;
        abc[0] = v_ins[1]; abc_e[0] = v_exp[1];
        abc[1] = v_ins[2]; abc_e[1] = v_exp[2];
        abc[2] = v_ins[3]; abc_e[2] = v_exp[3];
        k = 0;
        popped = 0;
        sb.delete();
        for (int c = 0; c < 10; c++) begin
            bus.out_ready = (c >= 4);
            bus.in_valid  = (k < 3);
            bus.instr     = 32'h0;
            if (k < 3) bus.instr = abc[k];
            if (c == 1) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_ready_one got=%b want=1", bus.in_ready);
                end
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_ready_full c=%0d got=%b want=0", c, bus.in_ready);
                end
                checks++;
                if (bus.out_valid !== 1'b1 || obs() !== abc_e[0]) begin
                    errors++;
                    $display("FAIL bp_hold c=%0d got=%b/%b want=1/%b", c, bus.out_valid, obs(), abc_e[0]);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                popped++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL bp_dup got=%b want=none", obs());
                end else begin
                    e = sb.pop_front();
                    if (obs() !== e) begin
                        errors++;
                        $display("FAIL bp_order c=%0d got=%b want=%b", c, obs(), e);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(abc_e[k]);
                k++;
            end
            step();
        end
        checks++;
        if (popped != 3 || sb.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_count got=%0d/%0d/%b want=3/0/0", popped, sb.size(), bus.out_valid);
        end
    endtask

    task automatic test_random();
        int   sent;
        int   got;
        int   cyc;
        int   idx;
        logic prev_stall;
        exp_t prev_obs;
        exp_t e;
        sent = 0;
        got = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_obs = '0;
        sb.delete();
        while ((sent < NR || sb.size() != 0) && cyc < 60000) begin
            idx = $urandom_range(0, NV - 1);
            bus.in_valid  = (sent < NR) && ($urandom_range(0, 9) < 7);
            bus.instr     = v_ins[idx] ^ ($urandom & 32'h000F8F80);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || obs() !== prev_obs) begin
                    errors++;
                    $display("FAIL rnd_stable cyc=%0d got=%b/%b want=1/%b", cyc, bus.out_valid, obs(), prev_obs);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                got++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious cyc=%0d got=%b want=none", cyc, obs());
                end else begin
                    e = sb.pop_front();
                    if (obs() !== e) begin
                        errors++;
                        $display("FAIL rnd_order cyc=%0d got=%b want=%b", cyc, obs(), e);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(v_exp[idx]);
                sent++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_obs = obs();
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != NR || sb.size() != 0) begin
            errors++;
            $display("FAIL rnd_count got=%0d left=%0d want=%0d/0", got, sb.size(), NR);
        end
    endtask

    task automatic test_reset_full();
        sb.delete();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = v_ins[3];
        step();
        bus.instr     = v_ins[4];
        step();
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rf_fill got=%b/%b want=0/1", bus.in_ready, bus.out_valid);
        end
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr    = v_ins[0];
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rf_flags got=%b/%b want=0/1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (obs() !== 7'b1111_000) begin
            errors++;
            $display("FAIL rf_outputs got=%b want=1111000", obs());
        end
        step();
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rf_stale c=%0d got=%b want=0", c, bus.out_valid);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.instr     = 32'h0;
        bus.out_ready = 1'b0;
        load_vectors();
        test_reset();
        test_decode();
        test_back_to_back();
        test_random();
        test_reset_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
